// File: rtl/adder_result_display_if.sv
// Board-side bundle for the result display: adder operands/sum and load button in,
// digit enables, segments, LEDs and the debug capture strobe out.
interface adder_result_display_if;
  logic [1:0] a;
  logic [1:0] b;
  logic [2:0] sum;
  logic       btn_load;
  logic [2:0] an;
  logic [6:0] seg;
  logic       carry_led;
  logic       valid_led;
  logic       load_pulse;

  modport master (
    output a, b, sum, btn_load,
    input  an, seg, carry_led, valid_led, load_pulse
  );

  modport slave (
    input  a, b, sum, btn_load,
    output an, seg, carry_led, valid_led, load_pulse
  );
endinterface

// File: rtl/adder_result_display.sv
// Captures the adder operands/sum on a debounced button press and shows a, b, sum
// on a 3-digit multiplexed 7-segment display with carry and valid LEDs.
module adder_result_display #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCAN_CYCLES     = 100_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_result_display_if.slave io
);
  localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SCW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCW-1:0] SC_MAX = SCW'(SCAN_CYCLES - 1);

  typedef enum logic [1:0] {DIG_SUM = 2'd0, DIG_B = 2'd1, DIG_A = 2'd2} digit_t;

  logic [1:0]     sync;
  logic           btn_s;
  logic           btn_db, btn_db_d;
  logic [DBW-1:0] db_cnt;
  logic           load_pulse;
  logic [1:0]     a_q, b_q;
  logic [2:0]     sum_q;
  logic           valid;
  logic [SCW-1:0] scan_cnt;
  logic           scan_wrap;
  digit_t         digit, digit_nxt;

  assign btn_s      = sync[1];
  assign load_pulse = btn_db & ~btn_db_d;
  assign scan_wrap  = (scan_cnt == SC_MAX);

  // Counter only runs while the synchronized level disagrees with the accepted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync     <= {sync[0], io.btn_load};
      btn_db_d <= btn_db;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      valid <= 1'b0;
    end else if (load_pulse) begin
      a_q   <= io.a;
      b_q   <= io.b;
      sum_q <= io.sum;
      valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      digit    <= DIG_SUM;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      digit    <= digit_nxt;
    end
  end

  always_comb begin
    digit_nxt = digit;
    if (scan_wrap) begin
      case (digit)
        DIG_SUM: digit_nxt = DIG_B;
        DIG_B:   digit_nxt = DIG_A;
        default: digit_nxt = DIG_SUM;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [2:0] v);
    case (v)
      3'd0:    seg7 = 7'h3F;
      3'd1:    seg7 = 7'h06;
      3'd2:    seg7 = 7'h5B;
      3'd3:    seg7 = 7'h4F;
      3'd4:    seg7 = 7'h66;
      3'd5:    seg7 = 7'h6D;
      3'd6:    seg7 = 7'h7D;
      default: seg7 = 7'h07;
    endcase
  endfunction

  // an and seg both derive from the registered digit, so they switch on the same edge.
  always_comb begin
    io.an  = 3'b001;
    io.seg = 7'h40;
    case (digit)
      DIG_B: begin
        io.an = 3'b010;
        if (valid) io.seg = seg7({1'b0, b_q});
      end
      DIG_A: begin
        io.an = 3'b100;
        if (valid) io.seg = seg7({1'b0, a_q});
      end
      default: begin
        io.an = 3'b001;
        if (valid) io.seg = seg7(sum_q);
      end
    endcase
  end

  assign io.carry_led  = sum_q[2];
  assign io.valid_led  = valid;
  assign io.load_pulse = load_pulse;
endmodule

// File: tb/tb_adder_result_display.sv
// Directed + randomized bench for adder_result_display with a cycle-level display model.
module tb_adder_result_display;
  localparam int D = 8;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_result_display_if io();

  adder_result_display #(.DEBOUNCE_CYCLES(D), .SCAN_CYCLES(S)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io.slave)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  int first_pulse = -1;
  int cyc0 = 0;
  int m_a = 0, m_b = 0, m_s = 0;
  bit m_valid = 1'b0;
  logic [6:0] segtab [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"}, 32'(io.an), 32'd1);
    chk({tag, "_seg"}, 32'(io.seg), 32'h40);
    chk({tag, "_carry"}, 32'(io.carry_led), 32'd0);
    chk({tag, "_valid"}, 32'(io.valid_led), 32'd0);
    chk({tag, "_pulse"}, 32'(io.load_pulse), 32'd0);
  endtask

  // Expected digit follows purely from cycles since reset release.
  task automatic check_display();
    int dig, val;
    dig = (cyc / S) % 3;
    val = (dig == 0) ? m_s : (dig == 1) ? m_b : m_a;
    chk("an", 32'(io.an), 32'(1 << dig));
    chk("seg", 32'(io.seg), m_valid ? 32'(segtab[val]) : 32'h40);
    chk("carry", 32'(io.carry_led), m_valid ? 32'((m_s >> 2) & 1) : 32'd0);
    chk("valid", 32'(io.valid_led), 32'(m_valid));
  endtask

  task automatic tick();
    logic lp;
    lp = io.load_pulse;
    @(posedge clk);
    #1;
    if (lp === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = cyc - cyc0;
      m_a = int'(io.a);
      m_b = int'(io.b);
      m_s = int'(io.sum);
      m_valid = 1'b1;
    end
    cyc++;
    check_display();
  endtask

  task automatic set_ops(input int na, input int nb, input int ns);
    io.a   = 2'(na);
    io.b   = 2'(nb);
    io.sum = 3'(ns);
  endtask

  task automatic press(input int hold, input string tag);
    int p0;
    p0 = pulses;
    cyc0 = cyc;
    first_pulse = -1;
    io.btn_load = 1'b1;
    repeat (hold) tick();
    io.btn_load = 1'b0;
    repeat (20) tick();
    chk({tag, "_npulse"}, 32'(pulses - p0), 32'd1);
    chk({tag, "_latency_ok"}, 32'(first_pulse >= D + 2 && first_pulse <= D + 4), 32'd1);
  endtask

  initial begin
    int p0;
    segtab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
    io.btn_load = 1'b0;
    set_ops(0, 0, 0);

    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;

    // Idle scan with dashes.
    repeat (40) tick();
    chk("idle_npulse", 32'(pulses), 32'd0);

    set_ops(3, 2, 5);
    press(20, "press1");

    // Bouncing button never settles long enough.
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      io.btn_load = ~io.btn_load;
      repeat (3) tick();
    end
    io.btn_load = 1'b0;
    repeat (20) tick();
    chk("bounce_npulse", 32'(pulses - p0), 32'd0);

    // Input changes without a press must not reach the display.
    set_ops(1, 1, 2);
    repeat (20) tick();
    press(20, "press2");

    set_ops(2, 3, 5);
    press(200, "long_press");

    for (int r = 0; r < 4; r++) begin
      int ra, rb;
      ra = int'($urandom_range(0, 3));
      rb = int'($urandom_range(0, 3));
      set_ops(ra, rb, ra + rb);
      press(20, "rand_press");
      set_ops(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      repeat (15) tick();
    end

    // Reset in the middle of a frame and a debounce.
    io.btn_load = 1'b1;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    io.btn_load = 1'b0;
    m_valid = 1'b0;
    m_a = 0; m_b = 0; m_s = 0;
    @(posedge clk); #1;
    chk_reset_outputs("inreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;
    p0 = pulses;
    io.btn_load = 1'b1;
    repeat (5) tick();
    io.btn_load = 1'b0;
    repeat (30) tick();
    chk("short_press_npulse", 32'(pulses - p0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
